// File: rtl/pci_arbiter_if.sv
// Shared PCI arbitration signals: per-initiator REQ#/GNT#, the bus FRAME#/IRDY# phases,
// and the arbiter's view of the current owner.
interface pci_arbiter_if #(
  parameter int N = 4
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req_n;
  logic             frame_n;
  logic             irdy_n;
  logic [N-1:0]     gnt_n;
  logic [IDX_W-1:0] owner;
  logic             busy;

  // Initiators drive requests and bus phases; the arbiter answers with grants.
  modport master (output req_n, frame_n, irdy_n, input gnt_n, owner, busy);
  modport slave  (input req_n, frame_n, irdy_n, output gnt_n, owner, busy);
endinterface

// File: rtl/pci_arbiter.sv
// Central PCI arbiter: round-robin grants with bus parking, hidden arbitration during
// a transfer, a one-cycle all-high gap on every handoff, and a dead-master timeout.
module pci_arbiter #(
  parameter int N       = 4,
  parameter int PARK    = 0,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst_n,
  pci_arbiter_if.slave bus
);
  localparam int               IDX_W    = $clog2(N);
  localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK);
  localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_PARK, S_GRANT, S_BUSY, S_DEAD} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_n_q, gnt_n_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             idle_q;

  logic [N-1:0]     req;
  logic             bus_idle, start, any_req, other_req;
  logic [IDX_W-1:0] winner;

  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] r, input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] w;
    logic [IDX_W-1:0] k;
    w = p;
    // Scan from the far end so the index closest to p wins.
    for (int i = N - 1; i >= 0; i--) begin
      k = IDX_W'((int'(p) + i) % N);
      if (r[k]) w = k;
    end
    return w;
  endfunction

  function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] x);
    return (int'(x) == N - 1) ? '0 : x + IDX_W'(1);
  endfunction

  function automatic logic [N-1:0] onehot_n(input logic [IDX_W-1:0] i);
    return ~(N'(1) << i);
  endfunction

  assign req       = ~bus.req_n;
  assign bus_idle  = bus.frame_n & bus.irdy_n;
  assign start     = ~bus.frame_n & idle_q;
  assign any_req   = |req;
  assign winner    = rr_pick(req, ptr_q);
  assign other_req = |(req & onehot_n(gidx_q));

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_PARK: begin
        if (start) begin
          state_d = S_BUSY;
          gidx_d  = PARK_IDX;
          owner_d = PARK_IDX;
        end else if (any_req) begin
          if (winner == PARK_IDX) begin
            state_d = S_GRANT;
            gidx_d  = PARK_IDX;
          end else begin
            state_d = S_DEAD;
          end
        end
      end
      S_GRANT: begin
        if (start) begin
          state_d = S_BUSY;
          owner_d = gidx_q;
          ptr_d   = inc_mod(gidx_q);
        end else if (!req[gidx_q]) begin
          state_d = S_DEAD;
        end else if (bus_idle && cnt_q >= TO_LAST) begin
          // Skip the silent master on the next arbitration round.
          state_d = S_DEAD;
          ptr_d   = inc_mod(gidx_q);
        end
      end
      S_BUSY: begin
        if (other_req) begin
          state_d = S_DEAD;
        end else if (bus_idle) begin
          if (req[gidx_q])             state_d = S_GRANT;
          else if (gidx_q == PARK_IDX) state_d = S_PARK;
          else                         state_d = S_DEAD;
        end
      end
      S_DEAD: begin
        if (any_req) begin
          state_d = S_GRANT;
          gidx_d  = winner;
        end else begin
          state_d = S_PARK;
          gidx_d  = PARK_IDX;
        end
      end
      default: state_d = S_PARK;
    endcase

    gnt_n_d = '1;
    case (state_d)
      S_PARK:  gnt_n_d = onehot_n(PARK_IDX);
      S_DEAD:  gnt_n_d = '1;
      default: gnt_n_d = onehot_n(gidx_d);
    endcase

    busy_d = busy_q;
    if (start)         busy_d = 1'b1;
    else if (bus_idle) busy_d = 1'b0;

    cnt_d = cnt_q;
    if (start || gnt_n_d != gnt_n_q)                          cnt_d = '0;
    else if (state_q == S_GRANT && bus_idle && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_PARK;
      gidx_q  <= PARK_IDX;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_n_q <= onehot_n(PARK_IDX);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_n_q <= gnt_n_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      idle_q  <= bus_idle;
    end
  end

  assign bus.gnt_n = gnt_n_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
endmodule
